// File: rtl/store_strobe_buffer_pkg.sv
// Store-type encodings, buffer entry layout and the 32-bit word strobe/data
// placement shared by the store strobe decoder and the store buffer.
package store_strobe_buffer_pkg;

  localparam logic [2:0] STORETYPE_SB  = 3'd0;
  localparam logic [2:0] STORETYPE_SH  = 3'd1;
  localparam logic [2:0] STORETYPE_SWL = 3'd2;
  localparam logic [2:0] STORETYPE_SW  = 3'd3;
  localparam logic [2:0] STORETYPE_SWR = 3'd6;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  // Entries are sized for the widest port; narrower ports zero the upper part.
  typedef struct packed {
    logic [31:0]           addr;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_STRB_W-1:0] wstrb;
  } SbEntry;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } WordLane;

  function automatic WordLane wordLaneShift(input logic [2:0]  storeType,
                                            input logic [1:0]  ofs,
                                            input logic [31:0] rt);
    WordLane r;
    r.strb = 4'b0000;
    r.data = rt;
    case (storeType)
      STORETYPE_SW:  r.strb = 4'b1111;
      STORETYPE_SH: begin
        r.strb = ofs[1] ? 4'b1100 : 4'b0011;
        r.data = {2{rt[15:0]}};
      end
      STORETYPE_SB: begin
        r.strb = 4'b0001 << ofs;
        r.data = {4{rt[7:0]}};
      end
      // SWL writes the upper bytes of rt into the low end of the word.
      STORETYPE_SWL: begin
        r.strb = 4'((5'd2 << ofs) - 5'd1);
        r.data = rt >> {2'd3 - ofs, 3'b000};
      end
      STORETYPE_SWR: begin
        r.strb = 4'b1111 << ofs;
        r.data = rt << {ofs, 3'b000};
      end
      default: r.strb = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_strobe_decode.sv
// Combinational per-store decode: lane-placed data, byte strobe for the
// D-cache port width, misalignment and type legality.
module store_strobe_decode
  import store_strobe_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic [OFS_W-1:0]    addrLow,
  input  logic [31:0]         storeData,
  input  logic [2:0]          storeType,
  output logic [DATA_W-1:0]   laneData,
  output logic [DATA_W/8-1:0] laneStrb,
  output logic                misalign,
  output logic                legal
);

  WordLane word;
  logic    typeKnown;

  assign word     = wordLaneShift(storeType, addrLow[1:0], storeData);
  assign laneData = {(DATA_W / 32){word.data}};

  if (DATA_W == 64) begin : gWide
    assign laneStrb = addrLow[OFS_W-1] ? {word.strb, 4'b0000} : {4'b0000, word.strb};
  end else begin : gNarrow
    assign laneStrb = word.strb;
  end

  always_comb begin
    misalign  = 1'b0;
    typeKnown = 1'b0;
    case (storeType)
      STORETYPE_SW: begin
        typeKnown = 1'b1;
        misalign  = (addrLow[1:0] != 2'b00);
      end
      STORETYPE_SH: begin
        typeKnown = 1'b1;
        misalign  = addrLow[0];
      end
      STORETYPE_SB, STORETYPE_SWL, STORETYPE_SWR: typeKnown = 1'b1;
      default: typeKnown = 1'b0;
    endcase
  end

  assign legal = typeKnown & ~misalign;

endmodule

// File: rtl/store_strobe_buffer.sv
// Store buffer between EXE/MEM and the D-cache write port: decodes each store,
// queues legal ones (merging into the tail when possible) and drains in order.
module store_strobe_buffer
  import store_strobe_buffer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter bit MERGE_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_data,
  input  logic [2:0]               in_type,
  output logic                     except_wr_misalign,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [DATA_W/8-1:0]      out_wstrb,
  input  logic [31:0]              ld_addr,
  output logic                     ld_conflict,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [31:0] ADDR_MASK = ~32'(STRB_W - 1);

  SbEntry            entries [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [PTR_W-1:0]  tailLast;
  logic [PTR_W-1:0]  relIdx;
  logic [DATA_W-1:0] laneData;
  logic [STRB_W-1:0] laneStrb;
  logic              misalign;
  logic              legal;
  logic [31:0]       reqAddr;
  logic              mergeHit;
  logic              accept;
  logic              doEnq;
  logic              doMerge;
  logic              doDeq;

  store_strobe_decode #(.DATA_W(DATA_W)) uDecode (
    .addrLow   (in_addr[OFS_W-1:0]),
    .storeData (in_data),
    .storeType (in_type),
    .laneData  (laneData),
    .laneStrb  (laneStrb),
    .misalign  (misalign),
    .legal     (legal)
  );

  assign reqAddr  = in_addr & ADDR_MASK;
  assign tailLast = tailPtr - PTR_W'(1);

  // count>=2 keeps the head (already on the cache port) out of merging.
  assign mergeHit = MERGE_EN && (count >= CNT_W'(2)) && (entries[tailLast].addr == reqAddr);

  assign in_ready           = (count < CNT_W'(DEPTH)) | mergeHit;
  assign accept             = in_valid & in_ready;
  assign doMerge            = accept & legal & mergeHit;
  assign doEnq              = accept & legal & ~mergeHit;
  assign out_valid          = (count != '0);
  assign doDeq              = out_valid & out_ready;
  assign except_wr_misalign = in_valid & misalign;

  assign out_addr  = entries[headPtr].addr;
  assign out_data  = entries[headPtr].data[DATA_W-1:0];
  assign out_wstrb = entries[headPtr].wstrb[STRB_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (doEnq) begin
        entries[tailPtr].addr  <= reqAddr;
        entries[tailPtr].data  <= MAX_DATA_W'(laneData);
        entries[tailPtr].wstrb <= MAX_STRB_W'(laneStrb);
        tailPtr                <= tailPtr + PTR_W'(1);
      end
      if (doMerge) begin
        entries[tailLast].wstrb <= entries[tailLast].wstrb | MAX_STRB_W'(laneStrb);
        for (int b = 0; b < STRB_W; b++) begin
          if (laneStrb[b]) entries[tailLast].data[8*b +: 8] <= laneData[8*b +: 8];
        end
      end
      if (doDeq) headPtr <= headPtr + PTR_W'(1);
      case ({doEnq, doDeq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Only occupied slots (head-relative index below count) can conflict.
  always_comb begin
    ld_conflict = 1'b0;
    relIdx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      relIdx = PTR_W'(i) - headPtr;
      if (({1'b0, relIdx} < count) && (((entries[i].addr ^ ld_addr) & ADDR_MASK) == '0))
        ld_conflict = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_strobe_buffer.sv
// Directed bench for store_strobe_buffer: a 32-bit merging instance and a
// 64-bit non-merging instance share one stimulus stream.
module tb_store_strobe_buffer;
  import store_strobe_buffer_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [2:0]  in_type;
  logic        out_ready;
  logic [31:0] ld_addr;

  logic        inReadyA, misA, outValidA, ldConfA;
  logic [31:0] outAddrA;
  logic [31:0] outDataA;
  logic [3:0]  outStrbA;
  logic [2:0]  countA;

  logic        inReadyB, misB, outValidB, ldConfB;
  logic [31:0] outAddrB;
  logic [63:0] outDataB;
  logic [7:0]  outStrbB;
  logic [2:0]  countB;

  int tests;
  int failed;

  store_strobe_buffer #(.DATA_W(32), .DEPTH(4), .MERGE_EN(1'b1)) dutA (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(inReadyA),
    .in_addr(in_addr), .in_data(in_data), .in_type(in_type),
    .except_wr_misalign(misA),
    .out_valid(outValidA), .out_ready(out_ready),
    .out_addr(outAddrA), .out_data(outDataA), .out_wstrb(outStrbA),
    .ld_addr(ld_addr), .ld_conflict(ldConfA), .count(countA)
  );

  store_strobe_buffer #(.DATA_W(64), .DEPTH(4), .MERGE_EN(1'b0)) dutB (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(inReadyB),
    .in_addr(in_addr), .in_data(in_data), .in_type(in_type),
    .except_wr_misalign(misB),
    .out_valid(outValidB), .out_ready(out_ready),
    .out_addr(outAddrB), .out_data(outDataB), .out_wstrb(outStrbB),
    .ld_addr(ld_addr), .ld_conflict(ldConfB), .count(countB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_type  = t;
    in_addr  = a;
    in_data  = d;
  endtask

  // One store through the 32-bit instance with out_ready high: the new entry
  // becomes the head on the following edge while the previous one drains.
  task automatic sweep(input string tag, input logic [2:0] t, input logic [31:0] a,
                       input logic [3:0] expStrb, input logic [31:0] expData);
    drive(t, a, 32'hAABBCCDD);
    tick();
    in_valid = 1'b0;
    chk({tag, " strb"}, 64'(outStrbA), 64'(expStrb));
    chk({tag, " data"}, 64'(outDataA), 64'(expData));
    chk({tag, " count"}, 64'(countA), 64'd1);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    in_type   = STORETYPE_SW;
    out_ready = 1'b0;
    ld_addr   = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst out_valid", 64'(outValidA), 64'd0);
    chk("rst count", 64'(countA), 64'd0);
    chk("rst out_addr", 64'(outAddrA), 64'd0);
    chk("rst out_data", 64'(outDataA), 64'd0);
    chk("rst out_wstrb", 64'(outStrbA), 64'd0);
    chk("rst ld_conflict", 64'(ldConfA), 64'd0);
    chk("rst in_ready", 64'(inReadyA), 64'd1);
    chk("rst countB", 64'(countB), 64'd0);
    tick();
    rst = 1'b0;

    // decode sweep, 32-bit lanes, rt = 0xAABBCCDD
    out_ready = 1'b1;
    sweep("SW o0",  STORETYPE_SW,  32'h1000, 4'b1111, 32'hAABBCCDD);
    sweep("SH o0",  STORETYPE_SH,  32'h1000, 4'b0011, 32'hCCDDCCDD);
    sweep("SH o2",  STORETYPE_SH,  32'h1002, 4'b1100, 32'hCCDDCCDD);
    sweep("SB o0",  STORETYPE_SB,  32'h1000, 4'b0001, 32'hDDDDDDDD);
    sweep("SB o1",  STORETYPE_SB,  32'h1001, 4'b0010, 32'hDDDDDDDD);
    sweep("SB o2",  STORETYPE_SB,  32'h1002, 4'b0100, 32'hDDDDDDDD);
    sweep("SB o3",  STORETYPE_SB,  32'h1003, 4'b1000, 32'hDDDDDDDD);
    sweep("SWL o0", STORETYPE_SWL, 32'h1000, 4'b0001, 32'h000000AA);
    sweep("SWL o1", STORETYPE_SWL, 32'h1001, 4'b0011, 32'h0000AABB);
    sweep("SWL o2", STORETYPE_SWL, 32'h1002, 4'b0111, 32'h00AABBCC);
    sweep("SWL o3", STORETYPE_SWL, 32'h1003, 4'b1111, 32'hAABBCCDD);
    sweep("SWR o0", STORETYPE_SWR, 32'h1000, 4'b1111, 32'hAABBCCDD);
    sweep("SWR o1", STORETYPE_SWR, 32'h1001, 4'b1110, 32'hBBCCDD00);
    sweep("SWR o2", STORETYPE_SWR, 32'h1002, 4'b1100, 32'hCCDD0000);
    sweep("SWR o3", STORETYPE_SWR, 32'h1003, 4'b1000, 32'hDD000000);
    chk("sweep out_addr", 64'(outAddrA), 64'h1000);
    tick();
    chk("sweep drained count", 64'(countA), 64'd0);
    chk("sweep drained valid", 64'(outValidA), 64'd0);

    // misalignment
    out_ready = 1'b0;
    drive(STORETYPE_SW, 32'h1002, 32'h12345678);
    #1;
    chk("SW 1002 except", 64'(misA), 64'd1);
    chk("SW 1002 in_ready", 64'(inReadyA), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("SW 1002 count", 64'(countA), 64'd0);
    chk("except idle", 64'(misA), 64'd0);
    tick();
    drive(STORETYPE_SH, 32'h1001, 32'h0000BEEF);
    #1;
    chk("SH 1001 except", 64'(misA), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("SH 1001 count", 64'(countA), 64'd0);
    drive(STORETYPE_SH, 32'h1002, 32'h0000BEEF);
    #1;
    chk("SH 1002 except", 64'(misA), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("SH 1002 count", 64'(countA), 64'd1);
    chk("SH 1002 strb", 64'(outStrbA), 64'hC);
    chk("SH 1002 data", 64'(outDataA), 64'hBEEFBEEF);
    chk("SH 1002 addr", 64'(outAddrA), 64'h1000);
    drive(3'd7, 32'h1000, 32'h55555555);
    #1;
    chk("undef except", 64'(misA), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("undef count", 64'(countA), 64'd1);
    ld_addr = 32'h1003;
    #1;
    chk("ld 1003 conflict", 64'(ldConfA), 64'd1);
    ld_addr = 32'h1004;
    #1;
    chk("ld 1004 conflict", 64'(ldConfA), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mis drain count", 64'(countA), 64'd0);

    // fill and backpressure
    for (int i = 0; i < 4; i++) begin
      drive(STORETYPE_SW, 32'h2000 + 32'(16 * i), 32'h2000 + 32'(16 * i));
      #1;
      chk("fill in_ready", 64'(inReadyA), 64'd1);
      tick();
      chk("fill count", 64'(countA), 64'(i + 1));
    end
    drive(STORETYPE_SW, 32'h2040, 32'h2040);
    #1;
    chk("full in_ready", 64'(inReadyA), 64'd0);
    chk("full countB", 64'(countB), 64'd4);
    tick();
    chk("full hold count", 64'(countA), 64'd4);
    chk("full hold addr", 64'(outAddrA), 64'h2000);
    out_ready = 1'b1;
    #1;
    chk("full passthru in_ready", 64'(inReadyA), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("drain1 count", 64'(countA), 64'd3);
    chk("drain1 addr", 64'(outAddrA), 64'h2010);
    chk("drain1 data", 64'(outDataA), 64'h2010);
    tick();
    chk("drain2 count", 64'(countA), 64'd2);
    chk("drain2 addr", 64'(outAddrA), 64'h2020);
    tick();
    chk("drain3 count", 64'(countA), 64'd1);
    chk("drain3 addr", 64'(outAddrA), 64'h2030);
    tick();
    chk("drain4 count", 64'(countA), 64'd0);
    chk("drain4 valid", 64'(outValidA), 64'd0);
    out_ready = 1'b0;

    // tail merge (A merges, B does not)
    drive(STORETYPE_SW, 32'h0100, 32'h12345678);
    tick();
    drive(STORETYPE_SB, 32'h0204, 32'h00000011);
    tick();
    drive(STORETYPE_SB, 32'h0205, 32'h00000022);
    tick();
    in_valid = 1'b0;
    chk("merge countA", 64'(countA), 64'd2);
    chk("merge countB", 64'(countB), 64'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("merge tail addr", 64'(outAddrA), 64'h0204);
    chk("merge tail strb", 64'(outStrbA), 64'h3);
    chk("merge tail data", 64'(outDataA), 64'h11112211);
    chk("nomerge countB", 64'(countB), 64'd2);
    chk("nomerge addrB", 64'(outAddrB), 64'h0200);
    chk("nomerge strbB", 64'(outStrbB), 64'h10);
    chk("nomerge dataB", outDataB, 64'h11111111_11111111);

    // asynchronous reset with entries pending
    drive(STORETYPE_SW, 32'h0300, 32'h00000300);
    tick();
    drive(STORETYPE_SW, 32'h0310, 32'h00000310);
    tick();
    in_valid = 1'b0;
    chk("pre-rst count", 64'(countA), 64'd3);
    ld_addr = 32'h0312;
    #1;
    chk("pre-rst ld_conflict", 64'(ldConfA), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst out_valid", 64'(outValidA), 64'd0);
    chk("arst count", 64'(countA), 64'd0);
    chk("arst out_addr", 64'(outAddrA), 64'd0);
    chk("arst out_wstrb", 64'(outStrbA), 64'd0);
    chk("arst out_data", 64'(outDataA), 64'd0);
    chk("arst ld_conflict", 64'(ldConfA), 64'd0);
    chk("arst countB", 64'(countB), 64'd0);
    #1 rst = 1'b0;
    tick();
    drive(STORETYPE_SW, 32'h0400, 32'hCAFEF00D);
    #1;
    chk("post-rst pre-edge valid", 64'(outValidA), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("post-rst valid", 64'(outValidA), 64'd1);
    chk("post-rst addr", 64'(outAddrA), 64'h0400);
    chk("post-rst data", 64'(outDataA), 64'hCAFEF00D);
    chk("post-rst count", 64'(countA), 64'd1);

    // 64-bit lane placement
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("w64 empty countB", 64'(countB), 64'd0);
    drive(STORETYPE_SH, 32'h0206, 32'h0000BEEF);
    tick();
    in_valid = 1'b0;
    chk("w64 addr", 64'(outAddrB), 64'h0200);
    chk("w64 strb", 64'(outStrbB), 64'hC0);
    chk("w64 data", outDataB, 64'hBEEFBEEF_BEEFBEEF);
    ld_addr = 32'h0204;
    #1;
    chk("w64 ld 204 B", 64'(ldConfB), 64'd1);
    chk("w64 ld 204 A", 64'(ldConfA), 64'd1);
    ld_addr = 32'h0208;
    #1;
    chk("w64 ld 208 B", 64'(ldConfB), 64'd0);
    chk("w64 ld 208 A", 64'(ldConfA), 64'd0);
    ld_addr = 32'h0200;
    #1;
    chk("w64 ld 200 B", 64'(ldConfB), 64'd1);
    chk("w64 ld 200 A", 64'(ldConfA), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
